// File: rtl/pcs_pkg.sv
// Shared PCS constants and types for the 64b/66b transmit path.
package pcs_pkg;

    localparam int DATA_W = 64;
    localparam int HEAD_W = 2;
    localparam int SEQ_N  = DATA_W / HEAD_W + 1;

    localparam logic [1:0] SYNC_DATA     = 2'b01;
    localparam logic [1:0] SYNC_CTRL     = 2'b10;
    localparam logic [7:0] BLK_TYPE_IDLE = 8'h1E;

    // Idle control block: type byte in the low octet, eight /I/ codes (0x00) above it.
    localparam logic [63:0] IDLE_DATA = {56'h0, BLK_TYPE_IDLE};

    typedef struct packed {
        logic [HEAD_W-1:0] head;
        logic [DATA_W-1:0] data;
    } blk_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } gb_sched_state_e;

endpackage

// File: rtl/gb_seq_cnt.sv
// Modulo-SEQ_N gearbox sequence counter with last-slot and wrap flags.
module gb_seq_cnt #(
    parameter int SEQ_N = 33,
    parameter int SEQ_W = $clog2(SEQ_N)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    output logic [SEQ_W-1:0] cnt,
    output logic             last,
    output logic             wrap
);

    localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQ_N - 1);

    logic [SEQ_W-1:0] cnt_reg;
    logic [SEQ_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (en) begin
            cnt_next = (cnt_reg == SEQ_LAST) ? '0 : cnt_reg + SEQ_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == SEQ_LAST);
    assign wrap = en && (cnt_reg == SEQ_LAST);

endmodule

// File: rtl/gearbox_tx_sched.sv
// TX gearbox sequencer: numbers blocks, stalls the encoder in the drain slot,
// fills encoder underruns with idle blocks and cross-checks the gearbox full flag.
module gearbox_tx_sched #(
    parameter int                DATA_W    = 64,
    parameter int                HEAD_W    = 2,
    parameter int                SEQ_N     = DATA_W / HEAD_W + 1,
    parameter int                SEQ_W     = $clog2(SEQ_N),
    parameter int                CNT_W     = 32,
    parameter logic [DATA_W-1:0] IDLE_DATA = pcs_pkg::IDLE_DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              blk_v_i,
    input  logic [HEAD_W-1:0] blk_head_i,
    input  logic [DATA_W-1:0] blk_data_i,
    output logic              blk_ready_o,
    output logic              valid_o,
    output logic [SEQ_W-1:0]  seq_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              gb_full_v_i,
    output logic              err_o,
    output logic [CNT_W-1:0]  idle_cnt_o,
    output logic [CNT_W-1:0]  blk_cnt_o
);

    import pcs_pkg::*;

    localparam logic [HEAD_W-1:0] CTRL_HEAD = HEAD_W'(SYNC_CTRL);
    localparam logic [SEQ_W-1:0]  SEQ_LAST  = SEQ_W'(SEQ_N - 1);
    localparam int                STAT_BLK  = 0;
    localparam int                STAT_IDLE = 1;

    gb_sched_state_e state_reg;
    gb_sched_state_e state_next;

    logic [SEQ_W-1:0]  seq_q;
    logic              seq_last;
    logic              seq_wrap;
    logic              active;
    logic              take_blk;
    logic              ins_idle;
    logic [1:0]        stat_inc;

    logic              valid_reg;
    logic [SEQ_W-1:0]  seq_reg;
    logic [HEAD_W-1:0] head_reg;
    logic [DATA_W-1:0] data_reg;
    logic              err_reg;

    assign active = (state_reg != IDLE);

    gb_seq_cnt #(
        .SEQ_N (SEQ_N),
        .SEQ_W (SEQ_W)
    ) u_seq_cnt (
        .clk  (clk),
        .srst (reset),
        .en   (active),
        .cnt  (seq_q),
        .last (seq_last),
        .wrap (seq_wrap)
    );

    // Leaving RUN exactly on the drain slot completes the sequence in that
    // same cycle, so no extra STOP pass is needed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (en_i) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_next = seq_last ? IDLE : STOP;
                end
            end
            STOP: begin
                if (seq_wrap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        blk_ready_o = (state_reg == RUN) && !seq_last;
        take_blk    = blk_ready_o && blk_v_i;
        ins_idle    = active && !seq_last && !take_blk;
        stat_inc    = '0;
        stat_inc[STAT_BLK]  = take_blk;
        stat_inc[STAT_IDLE] = ins_idle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            seq_reg   <= '0;
            head_reg  <= CTRL_HEAD;
            data_reg  <= IDLE_DATA;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (active) begin
                valid_reg <= 1'b1;
                seq_reg   <= seq_q;
                // Drain slot leaves head/data untouched; the gearbox ignores them.
                if (take_blk) begin
                    head_reg <= blk_head_i;
                    data_reg <= blk_data_i;
                end else if (ins_idle) begin
                    head_reg <= CTRL_HEAD;
                    data_reg <= IDLE_DATA;
                end
            end else begin
                valid_reg <= 1'b0;
                seq_reg   <= '0;
            end
            if (valid_reg && (gb_full_v_i != (seq_reg == SEQ_LAST))) begin
                err_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (stat_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign valid_o    = valid_reg;
    assign seq_o      = seq_reg;
    assign head_o     = head_reg;
    assign data_o     = data_reg;
    assign err_o      = err_reg;
    assign blk_cnt_o  = g_stat[STAT_BLK].cnt_reg;
    assign idle_cnt_o = g_stat[STAT_IDLE].cnt_reg;

endmodule

// File: tb/tb_gearbox_tx_sched.sv
// Directed bench for gearbox_tx_sched: a reset/startup vector table followed by
// hand-written multi-cycle sequences (full run, underrun, stop, error, reset).
module tb_gearbox_tx_sched;

    localparam logic [63:0] IDLE_D = 64'h000000000000001E;
    localparam logic [1:0]  H_DATA = 2'b01;
    localparam logic [1:0]  H_CTRL = 2'b10;

    logic        clk;
    logic        reset;
    logic        en_i;
    logic        blk_v_i;
    logic [1:0]  blk_head_i;
    logic [63:0] blk_data_i;
    logic        gb_full_v_i;

    logic        blk_ready_o;
    logic        valid_o;
    logic [5:0]  seq_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;
    logic        err_o;
    logic [31:0] idle_cnt_o;
    logic [31:0] blk_cnt_o;

    logic        s_ready;
    logic        s_valid;
    logic [5:0]  s_seq;
    logic [1:0]  s_head;
    logic [63:0] s_data;
    logic        s_err;
    logic [3:0]  s_idle_cnt;
    logic [3:0]  s_blk_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic pv = 1'b0;
    int   ps = 0;

    gearbox_tx_sched dut (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en_i),
        .blk_v_i     (blk_v_i),
        .blk_head_i  (blk_head_i),
        .blk_data_i  (blk_data_i),
        .blk_ready_o (blk_ready_o),
        .valid_o     (valid_o),
        .seq_o       (seq_o),
        .head_o      (head_o),
        .data_o      (data_o),
        .gb_full_v_i (gb_full_v_i),
        .err_o       (err_o),
        .idle_cnt_o  (idle_cnt_o),
        .blk_cnt_o   (blk_cnt_o)
    );

    // Narrow-counter build sharing the same stimulus, to exercise saturation.
    gearbox_tx_sched #(.CNT_W(4)) dut_small (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en_i),
        .blk_v_i     (blk_v_i),
        .blk_head_i  (blk_head_i),
        .blk_data_i  (blk_data_i),
        .blk_ready_o (s_ready),
        .valid_o     (s_valid),
        .seq_o       (s_seq),
        .head_o      (s_head),
        .data_o      (s_data),
        .gb_full_v_i (gb_full_v_i),
        .err_o       (s_err),
        .idle_cnt_o  (s_idle_cnt),
        .blk_cnt_o   (s_blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check ready before the edge, drive inputs, check valid/seq after.
    // gb_full follows the bench's own expected seq_o unless force_full is set.
    task automatic cyc(input logic en, input logic v, input logic [63:0] d,
                       input logic er, input logic ev, input int es, input logic force_full);
        check("ready", 64'(blk_ready_o), 64'(er));
        en_i        = en;
        blk_v_i     = v;
        blk_head_i  = H_DATA;
        blk_data_i  = d;
        gb_full_v_i = force_full | (pv && ps == 32);
        @(posedge clk);
        #1;
        check("valid", 64'(valid_o), 64'(ev));
        check("seq", 64'(seq_o), 64'(es));
        $display("cyc t=%0t rst=%b en=%b v=%b full=%b -> valid=%b seq=%0d head=%b data=%h err=%b",
                 $time, reset, en, v, gb_full_v_i, valid_o, seq_o, head_o, data_o, err_o);
        pv = ev;
        ps = es;
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic        v;
        logic [1:0]  head;
        logic [63:0] data;
        logic        e_valid;
        int          e_seq;
        logic [1:0]  e_head;
        logic [63:0] e_data;
        logic        e_ready;
        int          e_blk;
        int          e_idle;
    } vec_t;

    vec_t tbl[7];
    logic [63:0] blk;

    initial begin
        reset       = 1'b1;
        en_i        = 1'b0;
        blk_v_i     = 1'b0;
        blk_head_i  = H_DATA;
        blk_data_i  = '0;
        gb_full_v_i = 1'b0;

        //          rst   en    v     head    data            valid seq eh      edata           rdy  blk idle
        tbl[0] = '{1'b1, 1'b0, 1'b0, H_DATA, 64'h0,          1'b0, 0, H_CTRL, IDLE_D,         1'b0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, H_DATA, 64'hAAAA,       1'b0, 0, H_CTRL, IDLE_D,         1'b1, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, H_DATA, 64'h1111,       1'b1, 0, H_DATA, 64'h1111,       1'b1, 1, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, H_DATA, 64'h2222,       1'b1, 1, H_DATA, 64'h2222,       1'b1, 2, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, H_DATA, 64'hDEAD,       1'b1, 2, H_CTRL, IDLE_D,         1'b1, 2, 1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, H_CTRL, 64'h3333,       1'b1, 3, H_CTRL, 64'h3333,       1'b1, 3, 1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, H_DATA, 64'h4444,       1'b0, 0, H_CTRL, IDLE_D,         1'b0, 0, 0};

        for (int i = 0; i < 7; i++) begin
            reset      = tbl[i].rst;
            en_i       = tbl[i].en;
            blk_v_i    = tbl[i].v;
            blk_head_i = tbl[i].head;
            blk_data_i = tbl[i].data;
            @(posedge clk);
            #1;
            $display("vec %0d: valid=%b seq=%0d head=%b data=%h ready=%b blk=%0d idle=%0d",
                     i, valid_o, seq_o, head_o, data_o, blk_ready_o, blk_cnt_o, idle_cnt_o);
            check("tbl_valid", 64'(valid_o), 64'(tbl[i].e_valid));
            check("tbl_seq", 64'(seq_o), 64'(tbl[i].e_seq));
            check("tbl_head", 64'(head_o), 64'(tbl[i].e_head));
            check("tbl_data", data_o, tbl[i].e_data);
            check("tbl_ready", 64'(blk_ready_o), 64'(tbl[i].e_ready));
            check("tbl_blk_cnt", 64'(blk_cnt_o), 64'(tbl[i].e_blk));
            check("tbl_idle_cnt", 64'(idle_cnt_o), 64'(tbl[i].e_idle));
            check("tbl_err", 64'(err_o), 64'(0));
        end
        reset = 1'b0;
        pv = 1'b0;
        ps = 0;

        // Continuous traffic: 64 blocks over 66 slots, drain slot stalls the encoder.
        cyc(1'b1, 1'b1, 64'hFFFF, 1'b0, 1'b0, 0, 1'b0);
        blk = 0;
        for (int c = 0; c < 66; c++) begin
            int s;
            logic rdy;
            s   = c % 33;
            rdy = (s != 32);
            cyc(1'b1, 1'b1, blk, rdy, 1'b1, s, 1'b0);
            if (rdy) begin
                check("run_head", 64'(head_o), 64'(H_DATA));
                check("run_data", data_o, blk);
                blk++;
            end
        end
        check("run_blk_cnt", 64'(blk_cnt_o), 64'd64);
        check("run_idle_cnt", 64'(idle_cnt_o), 64'd0);
        check("run_err", 64'(err_o), 64'd0);
        check("sat_blk_cnt", 64'(s_blk_cnt), 64'hF);

        // Encoder underrun in slots 5..7.
        for (int c = 0; c < 33; c++) begin
            logic rdy;
            logic v;
            rdy = (c != 32);
            v   = !(c >= 5 && c <= 7);
            cyc(1'b1, v, blk, rdy, 1'b1, c, 1'b0);
            if (rdy && v) begin
                check("ur_data", data_o, blk);
                blk++;
            end else if (rdy) begin
                check("ur_idle_head", 64'(head_o), 64'(H_CTRL));
                check("ur_idle_data", data_o, IDLE_D);
            end
        end
        check("ur_idle_cnt", 64'(idle_cnt_o), 64'd3);
        check("ur_blk_cnt", 64'(blk_cnt_o), 64'd93);

        // en_i falls together with the slot-10 block: block taken, rest idles to the drain.
        for (int c = 0; c < 33; c++) begin
            logic rdy;
            rdy = (c <= 10);
            cyc(c < 10, 1'b1, blk, rdy, 1'b1, c, 1'b0);
            if (rdy) begin
                check("stop_data", data_o, blk);
                blk++;
            end else if (c != 32) begin
                check("stop_idle_head", 64'(head_o), 64'(H_CTRL));
                check("stop_idle_data", data_o, IDLE_D);
            end
        end
        cyc(1'b0, 1'b1, blk, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, blk, 1'b0, 1'b0, 0, 1'b1);
        check("stop_blk_cnt", 64'(blk_cnt_o), 64'd104);
        check("stop_idle_cnt", 64'(idle_cnt_o), 64'd24);
        check("sat_idle_cnt", 64'(s_idle_cnt), 64'hF);
        check("idle_full_ignored", 64'(err_o), 64'd0);

        // Re-enable, then a wrong full flag while seq_o=15 sets the sticky error.
        cyc(1'b1, 1'b1, blk, 1'b0, 1'b0, 0, 1'b1);
        for (int c = 0; c < 66; c++) begin
            int s;
            logic rdy;
            s   = c % 33;
            rdy = (s != 32);
            if (c == 16) check("err_before", 64'(err_o), 64'd0);
            cyc(1'b1, 1'b1, blk, rdy, 1'b1, s, c == 16);
            if (c == 16) check("err_set", 64'(err_o), 64'd1);
            if (rdy) begin
                check("err_run_data", data_o, blk);
                blk++;
            end
        end
        check("err_sticky", 64'(err_o), 64'd1);

        // Reset mid-sequence with en_i held: back to reset values, restart at seq 0.
        for (int c = 0; c <= 20; c++) begin
            cyc(1'b1, 1'b1, blk, 1'b1, 1'b1, c, 1'b0);
            blk++;
        end
        reset = 1'b1;
        cyc(1'b1, 1'b1, blk, 1'b1, 1'b0, 0, 1'b0);
        check("rst_head", 64'(head_o), 64'(H_CTRL));
        check("rst_data", data_o, IDLE_D);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_blk_cnt", 64'(blk_cnt_o), 64'd0);
        check("rst_idle_cnt", 64'(idle_cnt_o), 64'd0);
        reset = 1'b0;
        cyc(1'b1, 1'b1, blk, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, blk, 1'b1, 1'b1, 0, 1'b0);
        check("restart_data", data_o, blk);
        check("restart_blk_cnt", 64'(blk_cnt_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gearbox_tx_sched.md
Name: gearbox_tx_sched

Overview:
- Sequencing controller in front of the 64b/66b TX gearbox path: sits between the PCS encoder and the scrambler.
- Accepts 66b blocks from the encoder over a valid/ready handshake.
- Generates the gearbox sequence number 0..SEQ_N-1 and stalls the encoder on the gearbox's slip slot (seq SEQ_N-1).
- Inserts idle control blocks when the encoder underruns, and cross-checks the gearbox full flag against the predicted slot.

Parameters:
DATA_W, 64, block payload width
HEAD_W, 2, sync header width
SEQ_N, DATA_W/HEAD_W+1 (33), sequence length; the last slot is the gearbox drain slot
SEQ_W, $clog2(SEQ_N) (6), sequence counter width
CNT_W, 32, width of statistics counters
IDLE_DATA, 64'h000000000000001E, idle control block payload (type 0x1E, eight /I/ 0x00), LSB first

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
en_i  in  1  enable transmission
blk_v_i  in  1  encoder block valid
blk_head_i  in  HEAD_W  encoder sync header
blk_data_i  in  DATA_W  encoder payload
blk_ready_o  out  1  block accepted when blk_v_i & blk_ready_o
valid_o  out  1  head_o/data_o/seq_o valid toward scrambler/gearbox
seq_o  out  SEQ_W  gearbox sequence number
head_o  out  HEAD_W  sync header to scrambler
data_o  out  DATA_W  payload to scrambler
gb_full_v_i  in  1  gearbox full_v_o, aligned to seq_o by fixed downstream pipeline
err_o  out  1  sticky: gearbox full flag disagrees with predicted slot
idle_cnt_o  out  CNT_W  count of inserted idle blocks, saturating
blk_cnt_o  out  CNT_W  count of accepted encoder blocks, saturating

Behaviour:
- Reset values: blk_ready_o=0, valid_o=0, seq_o=0, head_o=2'b10, data_o=IDLE_DATA, err_o=0, both counters 0, state IDLE.
- FSM states:
  - IDLE: en_i low; valid_o=0, blk_ready_o=0, seq held at 0.
  - RUN: normal operation.
  - STOP: en_i fell; the sequence completes before returning to IDLE.
- Transitions:
  - IDLE->RUN when en_i=1. The first valid_o cycle carries seq_o=0.
  - RUN->STOP when en_i=0.
  - STOP->IDLE after the cycle that emits seq_o=SEQ_N-1, so the gearbox never sees a partial sequence.
  - reset from any state -> IDLE next cycle. Reset mid-sequence discards position; the next run starts at seq 0.
- Internal counter seq_q advances by 1 each cycle in RUN/STOP and wraps SEQ_N-1 -> 0. No other wrap point.
- blk_ready_o is combinational: state==RUN and seq_q != SEQ_N-1. It is 0 in the drain slot, in STOP, and in IDLE.
- Output registers update every cycle in RUN/STOP. Latency is 1 cycle: a block accepted at edge t appears on head_o/data_o at t+1 with seq_o = seq_q(t).
- Slot with seq_q < SEQ_N-1:
  - If blk_v_i=1 (and in RUN): output the encoder block; blk_cnt_o++.
  - Otherwise (including every such slot in STOP): output head 2'b10 / IDLE_DATA; idle_cnt_o++.
- Drain slot (seq_q = SEQ_N-1): head_o/data_o hold their previous values (don't-care to the gearbox). Neither counter increments.
- Full-flag check, performed when valid_o=1:
  - gb_full_v_i must equal (seq_o == SEQ_N-1).
  - Any mismatch sets err_o, which holds until reset. The sequence is not disturbed.
  - gb_full_v_i is ignored when valid_o=0.
- Counters saturate at all-ones; they are not cleared by en_i.
- Simultaneous en_i fall and blk_v_i in a RUN slot: the block is accepted in that same cycle (ready was high), then the FSM enters STOP.

Decomposition:
- Shared package pcs_pkg holds:
  - constants HEAD_W, SEQ_N, SYNC_DATA=2'b01, SYNC_CTRL=2'b10, BLK_TYPE_IDLE=8'h1E, IDLE_DATA;
  - typedef blk_t (struct head, data);
  - enum gb_sched_state_e {IDLE, RUN, STOP}.
- One sub-module is natural: gb_seq_cnt, the modulo-SEQ_N counter with enable, wrap flag and last-slot flag.
- Statistics counters are inline saturating increments.

Test Plan:
- Reset, en_i=1, blk_v_i=1 continuously with data=index -> seq_o 0..32 repeating. blk_ready_o is low exactly when seq_o would be 32. 64 blocks take 66 cycles; blk_cnt_o=64, idle_cnt_o=0, err_o=0.
- blk_v_i=0 for seq slots 5..7 -> head_o=2'b10 and data_o=64'h1E in those slots, idle_cnt_o=3; the sequence is unbroken.
- Drop en_i at seq_o=10 -> slots 11..31 carry idle blocks, seq 32 is emitted, then valid_o=0 and seq held at 0. Re-enable -> first seq_o=0.
- Model gearbox full pulse at seq_o=32 -> err_o stays 0. Force gb_full_v_i=1 at seq_o=15 -> err_o=1 next cycle and remains 1 through later correct sequences.
- Assert reset at seq_o=20 mid-run with en_i held 1 -> outputs return to reset values for 1 cycle, then restart at seq_o=0. Counters read 0.
- Preload near saturation (CNT_W=4 build) -> blk_cnt_o sticks at 4'hF after 15+ blocks.
